dlbf_slave_capture_ctrl: RTL and testbench

- Sequences capture of the 64-bit AXI4-Stream input of the DLBF slave into its sample RAM.
- Works on a CSR-programmed schedule of niter blocks of block_size 32-bit words.
- Checks TLAST framing against the programmed block length and raises done/error status for the AXI-Lite CSR bank.
- Sits between the stream input and the RAM write port, in the 400 MHz stream domain.

---
 rtl/dlbf_slave_capture_ctrl.sv | 153 +++++++++++++++
 tb/tb_dlbf_slave_capture_ctrl.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dlbf_slave_capture_ctrl.sv
// Capture sequencer for the DLBF slave: moves 64-bit stream beats into the sample RAM
// over niter blocks of block_size 32-bit words, checking TLAST framing against the count.
module dlbf_slave_capture_ctrl #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 12
) (
  input  logic                  s_axis_clk,
  input  logic                  s_axis_rst,
  input  logic [7:0]            cfg_niter,
  input  logic [15:0]           cfg_block_size,
  input  logic                  ctrl_start,
  input  logic                  ctrl_abort,
  input  logic [DATA_W-1:0]     s_axis_tdata,
  input  logic [DATA_W/8-1:0]   s_axis_tkeep,
  input  logic                  s_axis_tvalid,
  input  logic                  s_axis_tlast,
  output logic                  s_axis_tready,
  output logic                  ram_we,
  output logic [ADDR_W-1:0]     ram_addr,
  output logic [DATA_W-1:0]     ram_wdata,
  output logic [DATA_W/8-1:0]   ram_wstrb,
  output logic                  sts_busy,
  output logic                  sts_done,
  output logic                  sts_err_tlast,
  output logic                  sts_err_cfg,
  output logic [7:0]            sts_blk_cnt
);

  localparam logic [23:0] CAP_BEATS = 24'd1 << ADDR_W;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t              state_r;
  logic [7:0]          niter_r;
  logic [15:0]         bpb_r;
  logic [15:0]         beat_in_blk_r;
  logic [ADDR_W-1:0]   addr_r;

  logic [15:0]         bpb_s;
  logic [23:0]         total_s;
  logic                cfg_bad_s;
  logic                hs_s;
  logic                last_beat_s;
  logic                final_blk_s;

  // Derived schedule from the live config (only consumed on the start cycle) and beat decode.
  always_comb begin
    bpb_s       = 16'((17'(cfg_block_size) + 17'd1) >> 1);
    total_s     = 24'(cfg_niter) * 24'(bpb_s);
    cfg_bad_s   = (cfg_niter == 8'd0) || (cfg_block_size == 16'd0) || (total_s > CAP_BEATS);
    hs_s        = s_axis_tvalid && s_axis_tready;
    last_beat_s = (beat_in_blk_r == (bpb_r - 16'd1));
    final_blk_s = ((sts_blk_cnt + 8'd1) == niter_r);
  end

  // Capture FSM, RAM write port register and status bank.
  always_ff @(posedge s_axis_clk or posedge s_axis_rst) begin
    if (s_axis_rst) begin
      state_r       <= ST_IDLE;
      niter_r       <= 8'd0;
      bpb_r         <= 16'd0;
      beat_in_blk_r <= 16'd0;
      addr_r        <= '0;
      s_axis_tready <= 1'b0;
      ram_we        <= 1'b0;
      ram_addr      <= '0;
      ram_wdata     <= '0;
      ram_wstrb     <= '0;
      sts_busy      <= 1'b0;
      sts_done      <= 1'b0;
      sts_err_tlast <= 1'b0;
      sts_err_cfg   <= 1'b0;
      sts_blk_cnt   <= 8'd0;
    end else begin
      // A beat the upstream saw accepted is always written, even under abort.
      ram_we <= 1'b0;
      if (hs_s) begin
        ram_we    <= 1'b1;
        ram_addr  <= addr_r;
        ram_wdata <= s_axis_tdata;
        ram_wstrb <= s_axis_tkeep;
      end

      if (ctrl_abort) begin
        state_r       <= ST_IDLE;
        s_axis_tready <= 1'b0;
        sts_busy      <= 1'b0;
        sts_done      <= 1'b0;
      end else begin
        case (state_r)
          ST_IDLE, ST_DONE: begin
            if (ctrl_start) begin
              niter_r       <= cfg_niter;
              bpb_r         <= bpb_s;
              beat_in_blk_r <= 16'd0;
              addr_r        <= '0;
              sts_blk_cnt   <= 8'd0;
              sts_err_tlast <= 1'b0;
              if (cfg_bad_s) begin
                state_r       <= ST_DONE;
                sts_err_cfg   <= 1'b1;
                sts_done      <= 1'b1;
                sts_busy      <= 1'b0;
                s_axis_tready <= 1'b0;
              end else begin
                state_r       <= ST_RUN;
                sts_err_cfg   <= 1'b0;
                sts_done      <= 1'b0;
                sts_busy      <= 1'b1;
                s_axis_tready <= 1'b1;
              end
            end
          end
          ST_RUN: begin
            if (hs_s) begin
              addr_r <= addr_r + {{(ADDR_W-1){1'b0}}, 1'b1};
              // Block boundaries come from the beat count; TLAST is only checked against it.
              if (last_beat_s) begin
                beat_in_blk_r <= 16'd0;
                sts_blk_cnt   <= sts_blk_cnt + 8'd1;
                if (!s_axis_tlast) begin
                  sts_err_tlast <= 1'b1;
                end
                if (final_blk_s) begin
                  state_r       <= ST_DONE;
                  s_axis_tready <= 1'b0;
                  sts_busy      <= 1'b0;
                  sts_done      <= 1'b1;
                end
              end else begin
                beat_in_blk_r <= beat_in_blk_r + 16'd1;
                if (s_axis_tlast) begin
                  sts_err_tlast <= 1'b1;
                end
              end
            end
          end
          default: begin
            state_r       <= ST_IDLE;
            s_axis_tready <= 1'b0;
            sts_busy      <= 1'b0;
            sts_done      <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_dlbf_slave_capture_ctrl.sv
// Randomized scoreboard bench for dlbf_slave_capture_ctrl: a beat-level model predicts every
// RAM write and the status bank; a monitor matches RAM writes against the expected queue.
module tb_dlbf_slave_capture_ctrl;
  localparam int DATA_W = 64;
  localparam int ADDR_W = 12;
  localparam int KEEP_W = DATA_W / 8;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic [7:0]          cfg_niter = 8'd0;
  logic [15:0]         cfg_block_size = 16'd0;
  logic                ctrl_start = 1'b0;
  logic                ctrl_abort = 1'b0;
  logic [DATA_W-1:0]   s_axis_tdata = '0;
  logic [KEEP_W-1:0]   s_axis_tkeep = '0;
  logic                s_axis_tvalid = 1'b0;
  logic                s_axis_tlast = 1'b0;
  logic                s_axis_tready;
  logic                ram_we;
  logic [ADDR_W-1:0]   ram_addr;
  logic [DATA_W-1:0]   ram_wdata;
  logic [KEEP_W-1:0]   ram_wstrb;
  logic                sts_busy, sts_done, sts_err_tlast, sts_err_cfg;
  logic [7:0]          sts_blk_cnt;

  dlbf_slave_capture_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .s_axis_clk(clk), .s_axis_rst(rst),
    .cfg_niter(cfg_niter), .cfg_block_size(cfg_block_size),
    .ctrl_start(ctrl_start), .ctrl_abort(ctrl_abort),
    .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tlast(s_axis_tlast),
    .s_axis_tready(s_axis_tready),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_wstrb(ram_wstrb),
    .sts_busy(sts_busy), .sts_done(sts_done), .sts_err_tlast(sts_err_tlast),
    .sts_err_cfg(sts_err_cfg), .sts_blk_cnt(sts_blk_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int                stamp;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic [KEEP_W-1:0] strb;
  } wr_t;
  wr_t exp_q[$];

  int n_vec = 0;
  int n_err = 0;

  // Reference status, as the capture rules say it should look.
  bit m_err_tlast = 1'b0;
  bit m_err_cfg   = 1'b0;
  int m_blk       = 0;
  int m_addr      = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard monitor: every RAM write must match the oldest predicted beat, one cycle after it.
  always @(negedge clk) begin : monitor
    wr_t e;
    if (!rst && ram_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_ram_we", 64'd1, 64'd0);
      end else begin
        e = exp_q.pop_front();
        chk("ram_addr", 64'(ram_addr), 64'(e.addr));
        chk("ram_wdata", ram_wdata, e.data);
        chk("ram_wstrb", 64'(ram_wstrb), 64'(e.strb));
        chk("ram_we_latency", 64'(cyc), 64'(e.stamp));
      end
    end
  end

  task automatic check_status(input string tag, input bit done, input bit busy);
    chk({tag, "_done"}, 64'(sts_done), 64'(done));
    chk({tag, "_busy"}, 64'(sts_busy), 64'(busy));
    chk({tag, "_err_tlast"}, 64'(sts_err_tlast), 64'(m_err_tlast));
    chk({tag, "_err_cfg"}, 64'(sts_err_cfg), 64'(m_err_cfg));
    chk({tag, "_blk_cnt"}, 64'(sts_blk_cnt), 64'(m_blk));
  endtask

  // One capture: vmode 0 = tvalid always, 1 = alternate cycles, 2 = random with random data.
  // bad_blk/bad_beat plant an early TLAST; mid_at, abort_at, rst_at trigger at that beat count.
  task automatic run(input int niter, input int bsz, input int bad_blk, input int bad_beat,
                     input int vmode, input int mid_at, input int abort_at, input int rst_at);
    int bpb, total, beat, bib, guard;
    bit cfg_err, v, is_last;
    logic [DATA_W-1:0] d;
    logic [KEEP_W-1:0] k;
    wr_t e;

    @(negedge clk);
    cfg_niter      = 8'(niter);
    cfg_block_size = 16'(bsz);
    ctrl_start     = 1'b1;
    bpb     = (bsz + 1) / 2;
    total   = niter * bpb;
    cfg_err = (niter == 0) || (bsz == 0) || (total > (1 << ADDR_W));
    m_err_tlast = 1'b0;
    m_err_cfg   = cfg_err;
    m_blk       = 0;
    m_addr      = 0;
    @(negedge clk);
    ctrl_start = 1'b0;
    if (cfg_err) begin
      total = 0;
      chk("cfg_err_done_early", 64'(sts_done), 64'd1);
      chk("cfg_err_tready", 64'(s_axis_tready), 64'd0);
    end

    beat = 0; bib = 0; guard = 0;
    while (beat < total) begin
      chk("tready_run", 64'(s_axis_tready), 64'd1);
      chk("busy_run", 64'(sts_busy), 64'd1);
      if (beat == abort_at) begin
        s_axis_tvalid = 1'b0;
        ctrl_abort    = 1'b1;
        @(negedge clk);
        ctrl_abort = 1'b0;
        chk("abort_tready", 64'(s_axis_tready), 64'd0);
        check_status("abort", 1'b0, 1'b0);
        @(negedge clk);
        return;
      end
      if (beat == rst_at) begin
        s_axis_tvalid = 1'b1;
        s_axis_tlast  = 1'b0;
        @(posedge clk);
        #1;
        chk("ram_we_before_rst", 64'(ram_we), 64'd1);
        rst = 1'b1;
        #1;
        chk("rst_drops_ram_we", 64'(ram_we), 64'd0);
        chk("rst_tready", 64'(s_axis_tready), 64'd0);
        m_err_tlast = 1'b0; m_err_cfg = 1'b0; m_blk = 0;
        check_status("rst_mid", 1'b0, 1'b0);
        @(negedge clk);
        s_axis_tvalid = 1'b0;
        rst = 1'b0;
        return;
      end
      ctrl_start = (beat == mid_at);
      if (ctrl_start) begin
        cfg_niter      = 8'($urandom_range(1, 255));
        cfg_block_size = 16'($urandom_range(1, 65535));
      end
      case (vmode)
        0:       v = 1'b1;
        1:       v = (guard % 2 == 0);
        default: v = ($urandom_range(0, 99) < 60);
      endcase
      is_last = (bib == bpb - 1);
      d = (vmode == 2) ? {$urandom, $urandom} : {32'(2 * bib + 1), 32'(2 * bib)};
      k = (is_last && (bsz % 2 == 1)) ? 8'h0F : 8'hFF;
      s_axis_tvalid = v;
      s_axis_tdata  = d;
      s_axis_tkeep  = k;
      s_axis_tlast  = is_last || (m_blk == bad_blk && bib == bad_beat);
      if (v) begin
        e.stamp = cyc + 1;
        e.addr  = ADDR_W'(m_addr);
        e.data  = d;
        e.strb  = k;
        exp_q.push_back(e);
        if (s_axis_tlast != is_last) m_err_tlast = 1'b1;
        m_addr++;
        beat++;
        bib++;
        if (bib == bpb) begin
          bib = 0;
          m_blk++;
        end
      end
      guard++;
      if (guard > 8 * total + 100) begin
        chk("capture_timeout", 64'(guard), 64'd0);
        break;
      end
      @(negedge clk);
    end

    // Capture finished: stream offered but never accepted again.
    ctrl_start    = 1'b0;
    s_axis_tvalid = 1'b1;
    s_axis_tlast  = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("tready_after", 64'(s_axis_tready), 64'd0);
      @(negedge clk);
    end
    s_axis_tvalid = 1'b0;
    check_status("end", 1'b1, 1'b0);
    chk("writes_outstanding", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_tready", 64'(s_axis_tready), 64'd0);
    chk("rst_ram_we", 64'(ram_we), 64'd0);
    chk("rst_ram_addr", 64'(ram_addr), 64'd0);
    check_status("rst", 1'b0, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_tready", 64'(s_axis_tready), 64'd0);

    run(4, 32, -1, -1, 0, -1, -1, -1);
    run(1, 5, -1, -1, 0, -1, -1, -1);
    run(2, 8, 0, 2, 0, -1, -1, -1);
    run(0, 32, -1, -1, 0, -1, -1, -1);
    run(255, 65535, -1, -1, 0, -1, -1, -1);
    run(3, 0, -1, -1, 0, -1, -1, -1);
    run(129, 64, -1, -1, 0, -1, -1, -1);
    run(4, 32, -1, -1, 2, -1, 5, -1);
    run(2, 6, -1, -1, 0, -1, -1, -1);
    run(3, 12, -1, -1, 1, 7, -1, -1);
    for (int i = 0; i < 6; i++) begin
      int ni, bs;
      ni = $urandom_range(1, 8);
      bs = $urandom_range(1, 40);
      if ($urandom_range(0, 1) == 1)
        run(ni, bs, $urandom_range(0, ni - 1), $urandom_range(0, (bs + 1) / 2 - 1), 2, -1, -1, -1);
      else
        run(ni, bs, -1, -1, 2, $urandom_range(0, 10), -1, -1);
    end
    run(2, 16, -1, -1, 0, -1, -1, 4);
    run(128, 64, -1, -1, 0, -1, -1, -1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
